// File: rtl/writeback_stage.sv
// writeback_stage: retires instructions from the memory stage and drives one registered register-file write per instruction
// Ports: clk, rst (async, active-low); i_valid/o_ready/o_stall handshake with the memory stage;
//        i_wback/i_wreg/i_result/i_load/i_funct3 describe the retiring instruction;
//        i_mem_rvalid/i_mem_rdata return load data; o_wback/o_wreg/o_wdata drive the register file;
//        o_retired counts retired instructions.
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int REG_W    = 5,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_wback,
    input  logic [REG_W-1:0]    i_wreg,
    input  logic [XLEN-1:0]     i_result,
    input  logic                i_load,
    input  logic [2:0]          i_funct3,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,
    output logic                o_wback,
    output logic [REG_W-1:0]    o_wreg,
    output logic [XLEN-1:0]     o_wdata,
    output logic                o_stall,
    output logic [RETIRE_W-1:0] o_retired
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t              state, state_n;
    logic                ld_wback, ld_wback_n;
    logic [REG_W-1:0]    ld_wreg, ld_wreg_n;
    logic [2:0]          ld_funct3, ld_funct3_n;
    logic [1:0]          ld_off, ld_off_n;
    logic                wback_n;
    logic [REG_W-1:0]    wreg_n;
    logic [XLEN-1:0]     wdata_n;
    logic [RETIRE_W-1:0] retired_n;
    logic [7:0]          lb;
    logic [15:0]         lh;
    logic                ld_ok;
    logic [XLEN-1:0]     ld_data;
    assign o_ready = (state == IDLE);
    assign o_stall = ~o_ready;
    assign lb      = i_mem_rdata[{ld_off, 3'b000} +: 8];
    // halfword lane picks on off[1] only; misaligned halves are not trapped
    assign lh      = ld_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    // funct3 3, 6 and 7 are not loads this stage understands
    assign ld_ok   = (ld_funct3[1:0] != 2'b11) && !(ld_funct3[2] && ld_funct3[1]);
    // funct3[2] selects zero-extension, funct3[1] word, funct3[0] half
    assign ld_data = !ld_ok        ? '0 :
                     ld_funct3[1]  ? i_mem_rdata :
                     ld_funct3[0]  ? {{(XLEN-16){lh[15] & ~ld_funct3[2]}}, lh} :
                                     {{(XLEN-8){lb[7] & ~ld_funct3[2]}}, lb};
    always_comb begin
        state_n     = state;
        ld_wback_n  = ld_wback;
        ld_wreg_n   = ld_wreg;
        ld_funct3_n = ld_funct3;
        ld_off_n    = ld_off;
        wback_n     = 1'b0;
        wreg_n      = o_wreg;
        wdata_n     = o_wdata;
        retired_n   = o_retired;
        if (state == IDLE && i_valid) begin
            if (i_load) begin
                ld_wback_n  = i_wback;
                ld_wreg_n   = i_wreg;
                ld_funct3_n = i_funct3;
                ld_off_n    = i_result[1:0];
                state_n     = WAIT_MEM;
            end else begin
                wback_n   = i_wback && (i_wreg != '0);
                wreg_n    = i_wreg;
                wdata_n   = i_result;
                retired_n = o_retired + 1'b1;
            end
        end else if (state == WAIT_MEM && i_mem_rvalid) begin
            wback_n   = ld_wback && ld_ok && (ld_wreg != '0);
            wreg_n    = ld_wreg;
            wdata_n   = ld_data;
            retired_n = o_retired + 1'b1;
            state_n   = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ld_wback  <= 1'b0;
            ld_wreg   <= '0;
            ld_funct3 <= '0;
            ld_off    <= '0;
            o_wback   <= 1'b0;
            o_wreg    <= '0;
            o_wdata   <= '0;
            o_retired <= '0;
        end else begin
            state     <= state_n;
            ld_wback  <= ld_wback_n;
            ld_wreg   <= ld_wreg_n;
            ld_funct3 <= ld_funct3_n;
            ld_off    <= ld_off_n;
            o_wback   <= wback_n;
            o_wreg    <= wreg_n;
            o_wdata   <= wdata_n;
            o_retired <= retired_n;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: vector table plus scoreboard check of writeback_stage
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0, i_wback = 1'b0, i_load = 1'b0, i_mem_rvalid = 1'b0;
    logic [4:0]  i_wreg = '0;
    logic [31:0] i_result = '0, i_mem_rdata = '0;
    logic [2:0]  i_funct3 = '0;
    logic        o_ready, o_wback, o_stall;
    logic [4:0]  o_wreg;
    logic [31:0] o_wdata, o_retired;
    writeback_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_wback(i_wback),
        .i_wreg(i_wreg), .i_result(i_result), .i_load(i_load), .i_funct3(i_funct3),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_wback(o_wback),
        .o_wreg(o_wreg), .o_wdata(o_wdata), .o_stall(o_stall), .o_retired(o_retired)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        load;
        logic        wback;
        logic [4:0]  wreg;
        logic [31:0] result;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          dly;
        logic        e_wb;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        chk_wreg;
    } vec_t;
    typedef struct {
        logic        wb;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        chk_wreg;
    } exp_t;
    vec_t        vecs[15];
    exp_t        q[$];
    int          tests = 0, fails = 0;
    int          n_ret = 0;
    logic [31:0] prev_ret = '0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            q.delete();
            prev_ret = '0;
        end else if (o_retired != prev_ret) begin
            chk("retire_step", o_retired, prev_ret + 1);
            if (q.size() == 0) begin
                chk("unexpected_retire", o_retired, prev_ret);
            end else begin
                e = q.pop_front();
                chk("wback", {31'b0, o_wback}, {31'b0, e.wb});
                chk("wdata", o_wdata, e.wdata);
                if (e.chk_wreg) chk("wreg", {27'b0, o_wreg}, {27'b0, e.wreg});
            end
            prev_ret = o_retired;
        end else if (o_wback) begin
            chk("idle_wback", {31'b0, o_wback}, 32'd0);
        end
    end
    task automatic push(input logic wb, input logic [4:0] wreg, input logic [31:0] wdata, input logic cw);
        exp_t e;
        e.wb = wb; e.wreg = wreg; e.wdata = wdata; e.chk_wreg = cw;
        q.push_back(e);
        n_ret++;
    endtask
    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_load = v.load; i_wback = v.wback; i_wreg = v.wreg;
        i_result = v.result; i_funct3 = v.f3;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("accept_timeout", 32'd0, 32'd1);
        else push(v.e_wb, v.e_wreg, v.e_wdata, v.chk_wreg);
        @(posedge clk);
        if (v.load) begin
            @(negedge clk);
            i_valid = 1'b0;
            repeat (v.dly) @(negedge clk);
            i_mem_rvalid = 1'b1; i_mem_rdata = v.rdata;
            @(negedge clk);
            i_mem_rvalid = 1'b0;
        end
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0; i_mem_rvalid = 1'b0;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t ld;
        vecs[0]  = '{1'b0, 1'b1, 5'd10, 32'd6725,     3'd0, 32'h0,         0, 1'b1, 5'd10, 32'd6725,     1'b1};
        vecs[1]  = '{1'b0, 1'b1, 5'd0,  32'd11,       3'd0, 32'h0,         0, 1'b0, 5'd0,  32'd11,       1'b1};
        vecs[2]  = '{1'b0, 1'b1, 5'd5,  32'h55,       3'd0, 32'h0,         0, 1'b1, 5'd5,  32'h55,       1'b1};
        vecs[3]  = '{1'b0, 1'b1, 5'd6,  32'hDEADBEEF, 3'd0, 32'h0,         0, 1'b1, 5'd6,  32'hDEADBEEF, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd9,  32'd3,        3'd0, 32'h0,         0, 1'b0, 5'd9,  32'd3,        1'b1};
        vecs[5]  = '{1'b1, 1'b1, 5'd1,  32'h100,      3'd0, 32'h8081F2F3,  0, 1'b1, 5'd1,  32'hFFFFFFF3, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 5'd2,  32'h103,      3'd4, 32'h8081F2F3,  1, 1'b1, 5'd2,  32'h00000080, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'h102,      3'd1, 32'h8081F2F3,  2, 1'b1, 5'd3,  32'hFFFF8081, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 5'd4,  32'h100,      3'd5, 32'h8081F2F3,  0, 1'b1, 5'd4,  32'h0000F2F3, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 5'd8,  32'h101,      3'd2, 32'h8081F2F3,  1, 1'b1, 5'd8,  32'h8081F2F3, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 5'd11, 32'h101,      3'd0, 32'h8081F2F3,  0, 1'b1, 5'd11, 32'hFFFFFFF2, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 5'd12, 32'h202,      3'd4, 32'h8081F2F3,  0, 1'b1, 5'd12, 32'h00000081, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 5'd13, 32'h103,      3'd1, 32'h8081F2F3,  0, 1'b1, 5'd13, 32'hFFFF8081, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 5'd0,  32'h100,      3'd2, 32'h8081F2F3,  0, 1'b0, 5'd0,  32'h8081F2F3, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 5'd7,  32'h100,      3'd3, 32'h8081F2F3,  1, 1'b0, 5'd7,  32'h0,        1'b0};
        repeat (2) @(negedge clk);
        chk("rst_wback",   {31'b0, o_wback}, 32'd0);
        chk("rst_wreg",    {27'b0, o_wreg},  32'd0);
        chk("rst_wdata",   o_wdata,          32'd0);
        chk("rst_retired", o_retired,        32'd0);
        chk("rst_ready",   {31'b0, o_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, o_stall}, 32'd0);
        for (int i = 0; i < 15; i++) send(vecs[i]);
        idle(3);
        chk("table_retired", o_retired, n_ret);
        // stray rvalid in IDLE: no write, no count
        @(negedge clk);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
        idle(3);
        chk("stray_retired", o_retired, n_ret);
        // load stall: rvalid three cycles after accept, ALU held during WAIT_MEM
        ld = vecs[9];
        ld.dly = 0;
        @(negedge clk);
        i_valid = 1'b1; i_load = 1'b1; i_wback = 1'b1; i_wreg = 5'd20;
        i_result = 32'h102; i_funct3 = 3'd5;
        chk("stall_pre_ready", {31'b0, o_ready}, 32'd1);
        push(1'b1, 5'd20, 32'h00008081, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_load = 1'b0; i_wback = 1'b1; i_wreg = 5'd21; i_result = 32'd77;
            chk("stall_ready", {31'b0, o_ready}, 32'd0);
            chk("stall_stall", {31'b0, o_stall}, 32'd1);
            if (k == 2) begin
                i_mem_rvalid = 1'b1; i_mem_rdata = ld.rdata;
            end
        end
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        chk("stall_write", {31'b0, o_wback}, 32'd1);
        chk("stall_resume_ready", {31'b0, o_ready}, 32'd1);
        push(1'b1, 5'd21, 32'd77, 1'b1);
        @(posedge clk);
        idle(3);
        chk("stall_retired", o_retired, n_ret);
        // reset while waiting on load data drops the load
        @(negedge clk);
        i_valid = 1'b1; i_load = 1'b1; i_wback = 1'b1; i_wreg = 5'd22;
        i_result = 32'h100; i_funct3 = 3'd2;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rw_in_wait", {31'b0, o_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_ret = 0;
        @(negedge clk);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        idle(3);
        chk("rw_retired", o_retired, 32'd0);
        chk("rw_ready",   {31'b0, o_ready}, 32'd1);
        chk("rw_wdata",   o_wdata, 32'd0);
        send(vecs[0]);
        idle(2);
        chk("rw_after_retired", o_retired, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
